dct_butterfly_stage: RTL and testbench
======================================

DCT_BUTTERFLY_STAGE -- requirements
Module: dct_butterfly_stage

Interface
REQ-001 SHALL have parameter SIZE, default 8: signed sample width.
REQ-002 SHALL have parameter APPROX_BITS, default 0: number of LSBs with approximate adding enabled.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: sample offered.
REQ-006 SHALL have port in_ready, output, 1 bit: stage accepts a sample.
REQ-007 SHALL have port in_data, input, SIZE bits, signed: input sample x[k].
REQ-008 SHALL have port out_valid, output, 1 bit: butterfly pair available.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the pair.
REQ-010 SHALL have port out_sum, output, SIZE+1 bits, signed: x[i]+x[7-i].
REQ-011 SHALL have port out_diff, output, SIZE+1 bits, signed: x[i]-x[7-i].
REQ-012 SHALL have port out_idx, output, 2 bits: pair index i, 0..3.
REQ-013 SHALL have port out_last, output, 1 bit: high when out_idx==3.

Function
REQ-014 SHALL implement a two-state FSM: LOAD and EMIT.
REQ-015 SHALL drive in_ready high only in LOAD; out_valid high only in EMIT.
REQ-016 SHALL transfer an input on in_valid && in_ready and store it into buffer slot load_cnt (3 bits, 0..7); load_cnt then increments.
REQ-017 SHALL leave load_cnt and the buffer unchanged on cycles with in_valid low in LOAD.
REQ-018 SHALL, on the 8th accepted sample (load_cnt==7), wrap load_cnt to 0, set out_idx to 0, and enter EMIT; out_valid first rises the cycle after that sample.
REQ-019 SHALL compute out_sum combinationally from the buffer as sign-extended x[i]+x[7-i], with i=out_idx, at width SIZE+1 and with no overflow.
REQ-020 SHALL compute out_diff as x[i] + ~x[7-i] + 1 (carry-in 1), sign-extended to SIZE+1, giving exact x[i]-x[7-i] when APPROX_BITS=0.
REQ-021 SHALL drive approx_en of both adders with mask (2^APPROX_BITS)-1; bits at and above APPROX_BITS are exact.
REQ-022 SHALL advance out_idx on out_valid && out_ready; on transfer with out_idx==3 it SHALL return to LOAD with out_idx 0.
REQ-023 SHALL hold out_sum, out_diff, out_idx and out_last stable while out_valid && !out_ready.
REQ-024 SHALL ignore in_valid in EMIT: no buffer write, no load_cnt change.
REQ-025 SHALL give a minimum block period of 12 cycles (8 load + 4 emit); loading and emitting do not overlap.
REQ-026 SHALL not let out_ready in LOAD affect any state.

Reset
REQ-027 SHALL, while rst is high, force state LOAD, load_cnt 0, out_idx 0 and all buffer slots 0, regardless of clk.
REQ-028 SHALL give these output values under reset: in_ready 1, out_valid 0, out_idx 0, out_last 0, out_sum 0, out_diff 0.
REQ-029 SHALL discard any partially loaded or partially emitted block when reset is asserted; the first sample accepted after release is x[0].

Structure
REQ-030 SHALL place the FSM state enum (LOAD, EMIT) and constant N_POINTS=8 in shared package dct_pkg.
REQ-031 SHALL instantiate the existing fa_nbits twice (SIZE, APPROX_BITS passed through): one for the sum, one for the difference with b=~x[7-i] and cin=1; the cout ports are unused.
REQ-032 SHALL contain no other sub-modules; the buffer is 8 x SIZE flip-flops.

Verification
REQ-033 SHALL cover: SIZE=8, APPROX_BITS=0; inputs 1,2,...,8 -> pairs (idx,sum,diff) = (0,9,-7), (1,9,-5), (2,9,-3), (3,9,-1); out_last only on idx 3.
REQ-034 SHALL cover: inputs 127,127,127,127,-128,-128,-128,-128 -> every sum = -1 and every diff = +255 (9-bit, no wrap).
REQ-035 SHALL cover: out_ready low for 3 cycles at idx 0 -> outputs frozen at (0,9,-7); idx 1 appears only after the handshake.
REQ-036 SHALL cover: in_valid held high throughout EMIT with value 99 -> 99 is never captured, and the next block loads cleanly.
REQ-037 SHALL cover: rst pulsed mid-cycle after 5 samples loaded -> in_ready=1 and out_valid=0 immediately; the next 8 samples 1..8 reproduce the REQ-033 result.
REQ-038 SHALL cover: in_valid toggled 1,0,1,0 while loading -> only valid cycles count; out_valid rises exactly one cycle after the 8th accepted sample.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point DCT butterfly stage: FSM states,
// block size and the mirror-index helper.
package dct_pkg;

  localparam int N_POINTS = 8;
  localparam int CNT_W    = 3;
  localparam int IDX_W    = 2;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Partner slot of pair index i: 7-i.
  function automatic logic [CNT_W-1:0] mirror_idx(input logic [IDX_W-1:0] i);
    return CNT_W'(N_POINTS - 1) - {1'b0, i};
  endfunction

endpackage

// File: rtl/fa_nbits.sv
// Ripple-carry adder on sign-extended operands (SIZE+1 bit result) with
// per-bit approximate cells in the low APPROX_BITS positions.
module fa_nbits #(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  input  logic [SIZE-1:0] approx_en,
  output logic [SIZE:0]   sum,
  output logic            cout
);

  localparam logic [SIZE-1:0] LEGAL_MASK = {SIZE{1'b1}} >> (SIZE - APPROX_BITS);

  logic [SIZE:0]   a_ext;
  logic [SIZE:0]   b_ext;
  logic [SIZE:0]   apx;
  logic [SIZE+1:0] carry;

  assign a_ext = {a[SIZE-1], a};
  assign b_ext = {b[SIZE-1], b};
  // Bits at and above APPROX_BITS always stay exact, whatever the caller asks.
  assign apx   = {1'b0, approx_en & LEGAL_MASK};

  // NOTE: combinational blocks give every output a value before any branch or
  // loop touches it, so no path can leave a bit unassigned and infer a latch.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i <= SIZE; i++) begin
      if (apx[i]) begin
        // Lower-part OR cell: cheap sum, carry only when both bits are set.
        sum[i]     = a_ext[i] | b_ext[i];
        carry[i+1] = a_ext[i] & b_ext[i];
      end else begin
        sum[i]     = a_ext[i] ^ b_ext[i] ^ carry[i];
        carry[i+1] = (a_ext[i] & b_ext[i]) | (carry[i] & (a_ext[i] ^ b_ext[i]));
      end
    end
  end

  assign cout = carry[SIZE+1];

endmodule

// File: rtl/dct_butterfly_stage.sv
// First DCT butterfly: buffers 8 samples, then emits the 4 pairs
// (x[i]+x[7-i], x[i]-x[7-i]) over a valid/ready handshake.
module dct_butterfly_stage
  import dct_pkg::*;
#(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [SIZE-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [SIZE:0]   out_sum,
  output logic signed [SIZE:0]   out_diff,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last
);

  localparam logic [SIZE-1:0] APPROX_MASK = {SIZE{1'b1}} >> (SIZE - APPROX_BITS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SIZE-1:0]  buf_q [N_POINTS];

  logic             wr_en;
  logic [SIZE-1:0]  x_lo;
  logic [SIZE-1:0]  x_hi;
  logic [SIZE:0]    sum_w;
  logic [SIZE:0]    diff_w;
  logic             cout_unused_sum;
  logic             cout_unused_diff;

  assign wr_en = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // NOTE: the sample buffer is cleared by reset on purpose: outputs are
  // computed combinationally from it and must read 0 while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_POINTS; k++) buf_q[k] <= '0;
    end else if (wr_en) begin
      buf_q[load_cnt_q] <= in_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    idx_d      = idx_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // 3-bit counter wraps 7 -> 0 on its own.
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == CNT_W'(N_POINTS - 1)) begin
            state_d = EMIT;
            idx_d   = '0;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == IDX_W'(N_POINTS / 2 - 1)) begin
            state_d = LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign x_lo = buf_q[idx_q];
  assign x_hi = buf_q[mirror_idx(idx_q)];

  fa_nbits #(
    .SIZE       (SIZE),
    .APPROX_BITS(APPROX_BITS)
  ) u_add_sum (
    .a        (x_lo),
    .b        (x_hi),
    .cin      (1'b0),
    .approx_en(APPROX_MASK),
    .sum      (sum_w),
    .cout     (cout_unused_sum)
  );

  // Subtraction as x_lo + ~x_hi + 1; sign extension of ~x_hi equals ~sext(x_hi).
  fa_nbits #(
    .SIZE       (SIZE),
    .APPROX_BITS(APPROX_BITS)
  ) u_add_diff (
    .a        (x_lo),
    .b        (~x_hi),
    .cin      (1'b1),
    .approx_en(APPROX_MASK),
    .sum      (diff_w),
    .cout     (cout_unused_diff)
  );

  assign out_sum  = sum_w;
  assign out_diff = diff_w;
  assign out_idx  = idx_q;
  assign out_last = (idx_q == IDX_W'(N_POINTS / 2 - 1));

endmodule

// File: tb/tb_dct_butterfly_stage.sv
// Directed self-checking bench for dct_butterfly_stage (SIZE=8, exact adders).
module tb_dct_butterfly_stage;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [8:0] out_sum;
  logic signed [8:0] out_diff;
  logic [1:0]        out_idx;
  logic              out_last;

  int checks   = 0;
  int failures = 0;

  int ramp     [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int ramp_sum [4] = '{9, 9, 9, 9};
  int ramp_diff[4] = '{-7, -5, -3, -1};
  int ext      [8] = '{127, 127, 127, 127, -128, -128, -128, -128};
  int ext_sum  [4] = '{-1, -1, -1, -1};
  int ext_diff [4] = '{255, 255, 255, 255};
  int tens     [8] = '{10, 20, 30, 40, 50, 60, 70, 80};
  int tens_sum [4] = '{90, 90, 90, 90};
  int tens_diff[4] = '{-70, -50, -30, -10};

  dct_butterfly_stage #(
    .SIZE       (8),
    .APPROX_BITS(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_diff (out_diff),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_block(input int v[8]);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(v[k]);
      check("load_ready", in_ready, 1);
      check("load_no_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic emit_block(input string tag, input int s[4], input int d[4]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_noready"}, in_ready, 0);
      check({tag, "_idx"}, out_idx, i);
      check({tag, "_sum"}, out_sum, s[i]);
      check({tag, "_diff"}, out_diff, d[i]);
      check({tag, "_last"}, out_last, (i == 3) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_back_ready"}, in_ready, 1);
    check({tag, "_back_novalid"}, out_valid, 0);
  endtask

  initial begin
    // Reset values before any clock edge.
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_diff", out_diff, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp 1..8; out_ready high during LOAD must not disturb anything.
    out_ready = 1'b1;
    load_block(ramp);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    emit_block("ramp", ramp_sum, ramp_diff);

    // Extreme values: 9-bit results must not wrap.
    load_block(ext);
    in_valid = 1'b0;
    emit_block("ext", ext_sum, ext_diff);

    // Backpressure at idx 0 for 3 cycles.
    load_block(ramp);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_idx", out_idx, 0);
      check("stall_sum", out_sum, 9);
      check("stall_diff", out_diff, -7);
      @(posedge clk);
      #1;
    end
    emit_block("stall", ramp_sum, ramp_diff);

    // in_valid held with 99 throughout EMIT must never be captured.
    load_block(ramp);
    in_data = 8'sd99;
    emit_block("ign99", ramp_sum, ramp_diff);
    in_valid = 1'b0;
    load_block(tens);
    in_valid = 1'b0;
    emit_block("tens", tens_sum, tens_diff);

    // Reset mid-block after 5 samples.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(50 + k);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_idx", out_idx, 0);
    check("midrst_out_sum", out_sum, 0);
    #1 rst = 1'b0;
    load_block(ramp);
    in_valid = 1'b0;
    emit_block("postrst", ramp_sum, ramp_diff);

    // in_valid toggled while loading: only valid cycles count.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      check("tog_pre_valid", out_valid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'sd55;
      if (k < 7) begin
        check("tog_gap_novalid", out_valid, 0);
        check("tog_gap_ready", in_ready, 1);
        @(posedge clk);
        #1;
      end else begin
        check("tog_rise_valid", out_valid, 1);
      end
    end
    emit_block("tog", ramp_sum, ramp_diff);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
